// File: rtl/register_file.sv
// 16 x 16-bit register file: two combinational read ports, one synchronous
// write port, R0 hardwired to zero, and a writeback-to-decode bypass so that
// a register being written this cycle is already visible on the read ports.
module register_file #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        SrcReg1,
  input  logic [3:0]        SrcReg2,
  input  logic [3:0]        DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] dst_oh;
  logic [NUM_REGS-1:0] src1_oh;
  logic [NUM_REGS-1:0] src2_oh;
  logic [DATA_W-1:0]   rd1;
  logic [DATA_W-1:0]   rd2;
  logic                wr_en;
  logic                byp1;
  logic                byp2;

  // 4-to-16 one-hot index decoders; bit 0 of the write decode is dropped so R0 never loads
  always_comb begin
    dst_oh  = NUM_REGS'(1) << DstReg;
    src1_oh = NUM_REGS'(1) << SrcReg1;
    src2_oh = NUM_REGS'(1) << SrcReg2;
    dst_oh[0] = 1'b0;
  end

  // A write is live only outside reset and only for a non-zero destination
  always_comb begin
    wr_en = WriteReg & rst & (DstReg != 4'd0);
    byp1  = wr_en & (SrcReg1 == DstReg);
    byp2  = wr_en & (SrcReg2 == DstReg);
  end

  // Next-state: only the addressed register takes DstData; R0 is pinned to zero
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (WriteReg && dst_oh[i]) begin
        regs_d[i] = DstData;
      end
    end
    regs_d[0] = '0;
  end

  // Register storage; reset clears every entry immediately, independent of clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // AND-OR read muxes driven by the one-hot source decodes; R0 contributes nothing
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      rd1 = rd1 | (regs_q[i] & {DATA_W{src1_oh[i]}});
      rd2 = rd2 | (regs_q[i] & {DATA_W{src2_oh[i]}});
    end
  end

  // Bypass selects the in-flight write data; outputs are forced to zero during reset
  always_comb begin
    SrcData1 = '0;
    SrcData2 = '0;
    if (rst) begin
      SrcData1 = byp1 ? DstData : rd1;
      SrcData2 = byp2 ? DstData : rd2;
    end
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] e1;
    logic [15:0] e2;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;

  register_file dut (
    .clk      (clk),
    .rst      (rst),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    logic [15:0] v;
    v = 16'(i) * 16'h1111;
    return (i == 0) ? 16'h0000 : (v ^ 16'h5A00);
  endfunction

  // Monitor: compares the read ports against each queued expectation when strobed
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (SrcData1 !== e.e1 || SrcData2 !== e.e2) begin
          errors++;
          $display("FAIL %s: SrcData1=%h SrcData2=%h required %h %h",
                   e.name, SrcData1, SrcData2, e.e1, e.e2);
        end
      end
    end
  end

  task automatic expect_rd(input string nm, input logic [15:0] e1, input logic [15:0] e2);
    #2;
    sb_q.push_back('{nm, e1, e2});
    -> chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d, input logic [15:0] v);
    WriteReg = 1'b1;
    DstReg   = d;
    DstData  = v;
    tick();
    WriteReg = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    WriteReg = 1'b0;
    DstReg   = 4'd0;
    DstData  = 16'h0000;
    SrcReg1  = 4'd0;
    SrcReg2  = 4'd0;

    // Reset held: reads zero everywhere, bypass suppressed despite live writes
    for (int i = 0; i < 16; i++) begin
      WriteReg = 1'b1;
      DstReg   = 4'(i);
      DstData  = 16'hFFFF;
      SrcReg1  = 4'(i);
      SrcReg2  = 4'(15 - i);
      expect_rd($sformatf("reset_rd%0d", i), 16'h0000, 16'h0000);
    end
    WriteReg = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      SrcReg1 = 4'(i);
      SrcReg2 = 4'(15 - i);
      expect_rd($sformatf("post_reset_rd%0d", i), 16'h0000, 16'h0000);
    end

    // Basic write then read
    tick();
    wr(4'd2, 16'hA5A5);
    SrcReg1 = 4'd2;
    SrcReg2 = 4'd3;
    expect_rd("write_read", 16'hA5A5, 16'h0000);

    // Write disabled leaves R2 intact
    WriteReg = 1'b0;
    DstReg   = 4'd2;
    DstData  = 16'hFFFF;
    tick();
    expect_rd("write_disable", 16'hA5A5, 16'h0000);

    // R0 hardwired, including no bypass
    WriteReg = 1'b1;
    DstReg   = 4'd0;
    DstData  = 16'h1234;
    SrcReg1  = 4'd0;
    SrcReg2  = 4'd2;
    expect_rd("r0_pre_edge", 16'h0000, 16'hA5A5);
    tick();
    expect_rd("r0_post_edge", 16'h0000, 16'hA5A5);
    WriteReg = 1'b0;
    expect_rd("r0_idle", 16'h0000, 16'hA5A5);

    // Bypass on both ports, then on one port only
    wr(4'd5, 16'h0001);
    SrcReg1 = 4'd5;
    SrcReg2 = 4'd5;
    expect_rd("r5_loaded", 16'h0001, 16'h0001);
    WriteReg = 1'b1;
    DstReg   = 4'd5;
    DstData  = 16'hBEEF;
    expect_rd("bypass_both", 16'hBEEF, 16'hBEEF);
    SrcReg2 = 4'd2;
    expect_rd("bypass_port1_only", 16'hBEEF, 16'hA5A5);
    SrcReg2 = 4'd5;
    tick();
    WriteReg = 1'b0;
    expect_rd("bypass_stored", 16'hBEEF, 16'hBEEF);

    // Asynchronous reset in the middle of a pending write
    wr(4'd15, 16'h8001);
    SrcReg1 = 4'd15;
    SrcReg2 = 4'd5;
    expect_rd("r15_loaded", 16'h8001, 16'hBEEF);
    WriteReg = 1'b1;
    DstReg   = 4'd15;
    DstData  = 16'h7777;
    expect_rd("r15_bypass", 16'h7777, 16'hBEEF);
    rst = 1'b0;
    expect_rd("async_reset_now", 16'h0000, 16'h0000);
    tick();
    tick();
    expect_rd("reset_blocks_write", 16'h0000, 16'h0000);
    WriteReg = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expect_rd("after_release", 16'h0000, 16'h0000);

    // Exhaustive write of every register, then readback for aliasing
    tick();
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), pat(i) | ((i == 0) ? 16'hDEAD : 16'h0000));
    end
    for (int i = 0; i < 16; i++) begin
      SrcReg1 = 4'(i);
      SrcReg2 = 4'(15 - i);
      expect_rd($sformatf("readback%0d", i), pat(i), pat(15 - i));
    end

    #5;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 16-entry × 16-bit general-purpose register file for the processor datapath.
- Two combinational read ports feed the decode/execute stage.
- One synchronous write port is driven by writeback.
- R0 is hardwired to zero.
- Writeback-to-decode bypass: a register written in the current cycle is visible on the read ports in that same cycle.

Parameters:
- NUM_REGS, 16, number of registers; fixed, index width 4.
- DATA_W, 16, register width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- SrcReg1  input  4  register index for read port 1.
- SrcReg2  input  4  register index for read port 2.
- DstReg  input  4  register index for the write port.
- WriteReg  input  1  write enable, active-high.
- DstData  input  16  data to write into DstReg.
- SrcData1  output  16  read data for SrcReg1.
- SrcData2  output  16  read data for SrcReg2.

Behaviour:
- Storage: 16 registers R0..R15, 16 bits each. Index decoding is one-hot: 4-to-16 decoders for DstReg, SrcReg1 and SrcReg2.
- Reset:
  - rst low immediately clears R1..R15 to 16'h0000, independent of clk.
  - While rst is low, writes are blocked.
  - After rst rises, the first write takes effect on the next rising clk edge.
- Write:
  - On a rising clk edge with rst high and WriteReg = 1, R[DstReg] <= DstData.
  - WriteReg = 0 leaves all registers unchanged.
  - Only the addressed register changes.
- R0:
  - Always reads 16'h0000.
  - Writes to DstReg = 0 are discarded, including the bypass path.
- Read:
  - Combinational, zero-cycle latency: SrcDataN = R[SrcRegN].
  - Both ports are fully independent and may address the same register.
- Bypass:
  - Applies when WriteReg = 1, DstReg != 0 and SrcRegN == DstReg.
  - SrcDataN = DstData in the same cycle, before the clock edge.
  - After the edge, the stored value matches.
  - Applies to each port separately; both ports bypass if both match.
- Reset mid-operation: an asynchronous assertion overrides any pending write. Registers read zero; bypass is suppressed while rst is low.
- Outputs during reset: SrcData1 and SrcData2 = 16'h0000 for every index.
- Invariants:
  - No X on the outputs once reset has been applied.
  - No latches; reads are purely combinational from the flop outputs and bypass logic.

Test Plan:
- Reset:
  - Stimulus: assert rst = 0 asynchronously (no clk edge); sweep SrcReg1/SrcReg2 over 0..15.
  - Response: SrcData1 = SrcData2 = 16'h0000 immediately. Release rst = 1: all registers still read 0.
- Write/read:
  - Stimulus: WriteReg = 1, DstReg = 2, DstData = 16'hA5A5, one clk edge; then WriteReg = 0, SrcReg1 = 2, SrcReg2 = 3.
  - Response: SrcData1 = 16'hA5A5, SrcData2 = 16'h0000.
- Write disable:
  - Stimulus: WriteReg = 0, DstReg = 2, DstData = 16'hFFFF, clk edge.
  - Response: R2 still reads 16'hA5A5.
- R0 hardwired:
  - Stimulus: WriteReg = 1, DstReg = 0, DstData = 16'h1234, SrcReg1 = 0, before and after the edge.
  - Response: SrcData1 = 16'h0000 throughout.
- Bypass:
  - Stimulus: R5 = 16'h0001; then WriteReg = 1, DstReg = 5, DstData = 16'hBEEF, SrcReg1 = SrcReg2 = 5.
  - Response: before the edge SrcData1 = SrcData2 = 16'hBEEF; after the edge with WriteReg = 0, still 16'hBEEF.
- Async reset mid-operation:
  - Stimulus: load R15 = 16'h8001; drive rst = 0 mid-cycle with WriteReg = 1, DstReg = 15, DstData = 16'h7777; clock twice.
  - Response: R15 reads 16'h0000 at once; no write occurs while rst is low. Exhaustive write/readback of all 16 registers afterwards shows no aliasing.
